battleship_board_scan: RTL and testbench



---
 rtl/battleship_board_scan_if.sv | 37 +++
 rtl/battleship_board_scan.sv | 198 +++++++++++++++++++
 tb/tb_battleship_board_scan.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/battleship_board_scan_if.sv
// Player/matrix side signal bundle for battleship_board_scan.
// The master drives the cursor, fire and ship map; the slave (the board) drives results and LED lines.
interface battleship_board_scan_if #(
    parameter int N = 8
);
    localparam int CW = $clog2(N);
    localparam int HW = $clog2(N*N+1);

    logic            ship_load;
    logic [N*N-1:0]  ship_map;
    logic [CW-1:0]   cur_row;
    logic [CW-1:0]   cur_col;
    logic            fire;
    logic            fire_ready;
    logic            result_valid;
    logic            result_hit;
    logic            result_miss;
    logic            result_repeat;
    logic [HW-1:0]   hits;
    logic [15:0]     shots;
    logic            game_over;
    logic [N-1:0]    col_sel;
    logic [N-1:0]    out_r;
    logic [N-1:0]    out_g;

    modport master (
        output ship_load, ship_map, cur_row, cur_col, fire,
        input  fire_ready, result_valid, result_hit, result_miss, result_repeat,
               hits, shots, game_over, col_sel, out_r, out_g
    );

    modport slave (
        input  ship_load, ship_map, cur_row, cur_col, fire,
        output fire_ready, result_valid, result_hit, result_miss, result_repeat,
               hits, shots, game_over, col_sel, out_r, out_g
    );
endinterface

// File: rtl/battleship_board_scan.sv
// N x N battleship board with a fire/result shot FSM, hit/shot counters and a column-scanned
// red/green LED matrix driver. Optional macro CURSOR_BLINK_EN blinks the cursor every BLINK_FRAMES frames.
module battleship_board_scan #(
    parameter int N            = 8,
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 16
) (
    input logic clk,
    input logic rst,
    battleship_board_scan_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam int HW = $clog2(N*N+1);
    localparam int IW = $clog2(N*N);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {EMPTY, SHIP, HIT, MISS} cell_e;
    typedef enum logic [1:0] {IDLE, CHECK, RESULT, GAMEOVER} state_e;

    cell_e         board_q [N*N];
    state_e        state_q;
    logic          armed_q;
    logic [HW-1:0] shipsTotal_q;
    logic [HW-1:0] hits_q;
    logic [15:0]   shots_q;
    logic [CW-1:0] shotRow_q;
    logic [CW-1:0] shotCol_q;
    logic          resultValid_q;
    logic          resultHit_q;
    logic          resultMiss_q;
    logic          resultRepeat_q;
    logic          gameOver_q;

    logic          fireReady;
    logic [IW-1:0] shotIdx;
    cell_e         shotCell;

    function automatic logic [HW-1:0] popcount(input logic [N*N-1:0] map);
        logic [HW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N*N; i++) cnt = cnt + HW'(map[i]);
        return cnt;
    endfunction

    assign fireReady = (state_q == IDLE) && armed_q && !gameOver_q && !bus.ship_load;
    assign shotIdx   = IW'(shotRow_q) * IW'(N) + IW'(shotCol_q);
    assign shotCell  = board_q[shotIdx];

    // Shot FSM and board memory; a ship load outranks a simultaneous fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N*N; i++) board_q[i] <= EMPTY;
            state_q        <= IDLE;
            armed_q        <= 1'b0;
            shipsTotal_q   <= '0;
            hits_q         <= '0;
            shots_q        <= '0;
            shotRow_q      <= '0;
            shotCol_q      <= '0;
            resultValid_q  <= 1'b0;
            resultHit_q    <= 1'b0;
            resultMiss_q   <= 1'b0;
            resultRepeat_q <= 1'b0;
            gameOver_q     <= 1'b0;
        end else begin
            resultValid_q  <= 1'b0;
            resultHit_q    <= 1'b0;
            resultMiss_q   <= 1'b0;
            resultRepeat_q <= 1'b0;
            if (bus.ship_load && (state_q == IDLE || state_q == GAMEOVER)) begin
                for (int i = 0; i < N*N; i++) board_q[i] <= bus.ship_map[i] ? SHIP : EMPTY;
                shipsTotal_q <= popcount(bus.ship_map);
                armed_q      <= (bus.ship_map != '0);
                hits_q       <= '0;
                shots_q      <= '0;
                gameOver_q   <= 1'b0;
                state_q      <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.fire && fireReady) begin
                            shotRow_q <= bus.cur_row;
                            shotCol_q <= bus.cur_col;
                            state_q   <= CHECK;
                        end
                    end
                    CHECK: begin
                        unique case (shotCell)
                            SHIP: begin
                                board_q[shotIdx] <= HIT;
                                hits_q           <= hits_q + HW'(1);
                                resultHit_q      <= 1'b1;
                            end
                            EMPTY: begin
                                board_q[shotIdx] <= MISS;
                                resultMiss_q     <= 1'b1;
                            end
                            default: resultRepeat_q <= 1'b1;
                        endcase
                        if (shots_q != 16'hFFFF) shots_q <= shots_q + 16'd1;
                        resultValid_q <= 1'b1;
                        state_q       <= RESULT;
                    end
                    RESULT: begin
                        if (hits_q == shipsTotal_q) begin
                            state_q    <= GAMEOVER;
                            gameOver_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    GAMEOVER: gameOver_q <= 1'b1;
                    default:  state_q <= IDLE;
                endcase
            end
        end
    end

    logic [DW-1:0] div_q;
    logic [CW-1:0] col_q;
    logic [N-1:0]  colSel_q;
    logic [N-1:0]  outR_q;
    logic [N-1:0]  outG_q;
    logic [N-1:0]  nextR;
    logic [N-1:0]  nextG;
    logic          divWrap;
    logic          colWrap;
    logic          cursorOn;

    assign divWrap = (div_q == DW'(SCAN_DIV - 1));
    assign colWrap = divWrap && (col_q == CW'(N - 1));

`ifdef CURSOR_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] frame_q;
    logic          blinkPhase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q      <= '0;
            blinkPhase_q <= 1'b1;
        end else if (colWrap) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_q      <= '0;
                blinkPhase_q <= ~blinkPhase_q;
            end else begin
                frame_q <= frame_q + FW'(1);
            end
        end
    end

    assign cursorOn = blinkPhase_q;
`else
    assign cursorOn = 1'b1;
`endif

    // Ship cells stay dark so the opponent's fleet is never revealed.
    always_comb begin
        nextR = '0;
        nextG = '0;
        for (int r = 0; r < N; r++) begin
            nextR[r] = (board_q[IW'(r*N) + IW'(col_q)] == HIT);
            nextG[r] = (board_q[IW'(r*N) + IW'(col_q)] == MISS);
            if (cursorOn && (col_q == bus.cur_col) && (CW'(r) == bus.cur_row)) begin
                nextR[r] = 1'b1;
                nextG[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            col_q    <= '0;
            colSel_q <= '0;
            outR_q   <= '0;
            outG_q   <= '0;
        end else begin
            colSel_q <= N'(1) << col_q;
            outR_q   <= nextR;
            outG_q   <= nextG;
            div_q    <= divWrap ? '0 : div_q + DW'(1);
            if (divWrap) col_q <= colWrap ? '0 : col_q + CW'(1);
        end
    end

    assign bus.fire_ready    = fireReady;
    assign bus.result_valid  = resultValid_q;
    assign bus.result_hit    = resultHit_q;
    assign bus.result_miss   = resultMiss_q;
    assign bus.result_repeat = resultRepeat_q;
    assign bus.hits          = hits_q;
    assign bus.shots         = shots_q;
    assign bus.game_over     = gameOver_q;
    assign bus.col_sel       = colSel_q;
    assign bus.out_r         = outR_q;
    assign bus.out_g         = outG_q;
endmodule

// File: tb/tb_battleship_board_scan.sv
// Self-checking bench for battleship_board_scan: directed game plus randomized games checked
// against a cell-array game model and an arithmetic scan-position model.
`timescale 1ns/1ps
module tb_battleship_board_scan;
    localparam int N            = 8;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int CW           = $clog2(N);
    localparam int FRAME        = N * SCAN_DIV;
    localparam int C_EMPTY = 0, C_SHIP = 1, C_HIT = 2, C_MISS = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    battleship_board_scan_if #(.N(N)) bus ();

    battleship_board_scan #(
        .N(N), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int mb [N][N];
    int mTotal, mHits, mShots;
    bit mArmed, mOver;
    int tRow, tCol;
    int passCount = 0;
    int checkCount = 0;
    int cyc;

    // Clock edges seen since reset released; drives the expected scan position.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checkCount++;
        if (got === want) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic setCursor(input int r, input int c);
        tRow = r;
        tCol = c;
        bus.cur_row = CW'(r);
        bus.cur_col = CW'(c);
    endtask

    task automatic clearModel();
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mb[r][c] = C_EMPTY;
        mTotal = 0; mHits = 0; mShots = 0; mArmed = 0; mOver = 0;
    endtask

    task automatic scanExpect(input int k, output logic [N-1:0] sel, output logic [N-1:0] er,
                              output logic [N-1:0] eg);
        int col, frame;
        bit shown;
        col   = ((k - 1) / SCAN_DIV) % N;
        frame = (k - 1) / FRAME;
        shown = 1'b1;
`ifdef CURSOR_BLINK_EN
        shown = ((frame / BLINK_FRAMES) % 2) == 0;
`endif
        sel = '0;
        sel[col] = 1'b1;
        for (int r = 0; r < N; r++) begin
            er[r] = (mb[r][col] == C_HIT);
            eg[r] = (mb[r][col] == C_MISS);
            if (shown && r == tRow && col == tCol) begin
                er[r] = 1'b1;
                eg[r] = 1'b1;
            end
        end
    endtask

    task automatic checkScan(input int cycles);
        logic [N-1:0] sel, er, eg;
        repeat (cycles) begin
            @(negedge clk);
            scanExpect(cyc, sel, er, eg);
            checkOutput("col_sel", bus.col_sel, sel);
            checkOutput("out_r", bus.out_r, er);
            checkOutput("out_g", bus.out_g, eg);
        end
    endtask

    task automatic loadBoard(input logic [N*N-1:0] map, input bit withFire);
        bus.ship_map  = map;
        bus.ship_load = 1'b1;
        bus.fire      = withFire;
        #1 checkOutput("fire_ready_during_load", bus.fire_ready, 1'b0);
        @(negedge clk);
        bus.ship_load = 1'b0;
        bus.fire      = 1'b0;
        clearModel();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mb[r][c] = map[r*N + c] ? C_SHIP : C_EMPTY;
        mTotal = $countones(map);
        mArmed = (mTotal != 0);
        #1;
        checkOutput("load_hits", bus.hits, 0);
        checkOutput("load_shots", bus.shots, 0);
        checkOutput("load_game_over", bus.game_over, 0);
        checkOutput("load_fire_ready", bus.fire_ready, mArmed);
        if (withFire) begin
            repeat (2) begin
                @(negedge clk);
                checkOutput("load_fire_no_result", bus.result_valid, 0);
                checkOutput("load_fire_no_shot", bus.shots, 0);
            end
        end
    endtask

    // One fire request at (r,c); checks handshake, two-cycle result latency and counters.
    task automatic applyStimulus(input int r, input int c);
        bit ready, eHit, eMiss, eRep;
        ready = mArmed && !mOver;
        setCursor(r, c);
        bus.fire = 1'b1;
        #1 checkOutput("fire_ready", bus.fire_ready, ready);
        @(negedge clk);
        bus.fire = 1'b0;
        setCursor($urandom_range(N - 1), $urandom_range(N - 1));
        if (!ready) begin
            repeat (3) begin
                checkOutput("refused_no_result", bus.result_valid, 0);
                checkOutput("refused_shots", bus.shots, mShots);
                @(negedge clk);
            end
            return;
        end
        eHit = 0; eMiss = 0; eRep = 0;
        if (mb[r][c] == C_SHIP) begin
            eHit = 1; mb[r][c] = C_HIT; mHits++;
        end else if (mb[r][c] == C_EMPTY) begin
            eMiss = 1; mb[r][c] = C_MISS;
        end else begin
            eRep = 1;
        end
        if (mShots < 16'hFFFF) mShots++;
        checkOutput("check_cycle_valid", bus.result_valid, 0);
        checkOutput("check_cycle_hit_flag", bus.result_hit, 0);
        @(negedge clk);
        checkOutput("result_valid", bus.result_valid, 1);
        checkOutput("result_hit", bus.result_hit, eHit);
        checkOutput("result_miss", bus.result_miss, eMiss);
        checkOutput("result_repeat", bus.result_repeat, eRep);
        checkOutput("hits", bus.hits, mHits);
        checkOutput("shots", bus.shots, mShots);
        @(negedge clk);
        if (mHits == mTotal) mOver = 1;
        checkOutput("result_cleared", bus.result_valid, 0);
        checkOutput("result_flags_cleared", {bus.result_hit, bus.result_miss, bus.result_repeat}, 0);
        checkOutput("game_over", bus.game_over, mOver);
        checkOutput("fire_ready_after", bus.fire_ready, mArmed && !mOver);
    endtask

    task automatic randomGame();
        logic [N*N-1:0] map;
        map = '0;
        for (int i = 0; i < N*N; i++) map[i] = ($urandom_range(4) == 0);
        if (map == '0) map[$urandom_range(N*N - 1)] = 1'b1;
        loadBoard(map, 1'b0);
        for (int s = 0; s < 20 && !mOver; s++) begin
            applyStimulus($urandom_range(N - 1), $urandom_range(N - 1));
            if (s % 7 == 6) begin
                setCursor($urandom_range(N - 1), $urandom_range(N - 1));
                checkScan(FRAME);
            end
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (mb[r][c] == C_SHIP) applyStimulus(r, c);
        checkOutput("random_game_over", bus.game_over, 1);
        applyStimulus($urandom_range(N - 1), $urandom_range(N - 1));
    endtask

    initial begin
        logic [N*N-1:0] map;
        rst = 1'b1;
        bus.ship_load = 1'b0;
        bus.ship_map  = '0;
        bus.fire      = 1'b0;
        clearModel();
        setCursor(3, 4);
        repeat (2) @(negedge clk);
        checkOutput("reset_col_sel", bus.col_sel, 0);
        checkOutput("reset_out_r", bus.out_r, 0);
        checkOutput("reset_out_g", bus.out_g, 0);
        checkOutput("reset_result_valid", bus.result_valid, 0);
        checkOutput("reset_hits", bus.hits, 0);
        checkOutput("reset_shots", bus.shots, 0);
        checkOutput("reset_game_over", bus.game_over, 0);
        checkOutput("reset_fire_ready", bus.fire_ready, 0);
        rst = 1'b0;
        checkScan(2 * FRAME);

        map = '0;
        map[2*N + 3] = 1'b1;
        map[5*N + 5] = 1'b1;
        loadBoard(map, 1'b0);
        applyStimulus(2, 3);
        setCursor(7, 7);
        checkScan(FRAME);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        setCursor(6, 1);
        checkScan(FRAME);
        applyStimulus(5, 5);
        applyStimulus(1, 1);
        setCursor(2, 3);
        checkScan(4 * FRAME);

        map = '0;
        map[1*N + 1] = 1'b1;
        map[4*N + 6] = 1'b1;
        loadBoard(map, 1'b1);
        applyStimulus(4, 6);
        applyStimulus(0, 7);

        setCursor(1, 1);
        bus.fire = 1'b1;
        @(negedge clk);
        bus.fire = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        clearModel();
        checkOutput("midshot_reset_valid", bus.result_valid, 0);
        checkOutput("midshot_reset_hits", bus.hits, 0);
        checkOutput("midshot_reset_shots", bus.shots, 0);
        checkOutput("midshot_reset_col_sel", bus.col_sel, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_reset_valid", bus.result_valid, 0);
            checkOutput("post_reset_fire_ready", bus.fire_ready, 0);
        end
        checkScan(FRAME);

        repeat (3) randomGame();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
